// File: rtl/spi_ram_slave_ctrl.sv
// SPI slave front-end for the single-port SPI RAM.
// Deserialises MOSI frames into {cmd, payload} words for the RAM and
// serialises returned read data onto MISO. Everything runs on clk.
module spi_ram_slave_ctrl #(
    parameter int RX_W        = 10,
    parameter int TX_W        = 8,
    parameter int TX_WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int BIT_CW  = $clog2(RX_W + 1);
    localparam int TX_CW   = $clog2(TX_W + 1);
    localparam int WAIT_CW = $clog2(TX_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [BIT_CW-1:0]  bit_cnt_r, bit_cnt_s;      // bits of the current frame received
    logic [RX_W-2:0]    shift_r, shift_s;          // bits received before the current one
    logic [RX_W-1:0]    rx_data_s;
    logic               rx_valid_s;
    logic               rd_addr_done_r, rd_addr_done_s;
    logic [TX_W-1:0]    tx_shift_r, tx_shift_s;
    logic [TX_CW-1:0]   tx_cnt_r, tx_cnt_s;        // MISO bits still to drive
    logic               wait_act_r, wait_act_s;    // waiting for the RAM's read data
    logic [WAIT_CW-1:0] wait_cnt_r, wait_cnt_s;    // sampling edges spent waiting
    logic               miso_s;

    // Next-state and next-output logic for the frame sequencer and MISO serialiser.
    always_comb begin
        state_s        = state_r;
        bit_cnt_s      = bit_cnt_r;
        shift_s        = shift_r;
        rx_data_s      = rx_data;
        rx_valid_s     = 1'b0;
        rd_addr_done_s = rd_addr_done_r;
        tx_shift_s     = tx_shift_r;
        tx_cnt_s       = tx_cnt_r;
        wait_act_s     = wait_act_r;
        wait_cnt_s     = wait_cnt_r;
        miso_s         = 1'b0;

        case (state_r)
            IDLE: begin
                bit_cnt_s  = '0;
                tx_cnt_s   = '0;
                wait_act_s = 1'b0;
                if (!SS_n) begin
                    state_s = CHK_CMD;
                end else begin
                    state_s = IDLE;
                end
            end

            CHK_CMD: begin
                if (SS_n) begin
                    state_s = IDLE;
                end else begin
                    // First bit of the frame decides the path.
                    shift_s   = {{(RX_W-2){1'b0}}, MOSI};
                    bit_cnt_s = BIT_CW'(1);
                    if (!MOSI) begin
                        state_s = WRITE;
                    end else if (!rd_addr_done_r) begin
                        state_s = READ_ADD;
                    end else begin
                        state_s = READ_DATA;
                    end
                end
            end

            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    // Deselect aborts the frame and any shift-out; rd_addr_done is kept.
                    state_s    = IDLE;
                    tx_cnt_s   = '0;
                    wait_act_s = 1'b0;
                end else begin
                    if (bit_cnt_r < BIT_CW'(RX_W)) begin
                        shift_s   = {shift_r[RX_W-3:0], MOSI};
                        bit_cnt_s = bit_cnt_r + BIT_CW'(1);
                        if (bit_cnt_r == BIT_CW'(RX_W - 1)) begin
                            rx_data_s  = {shift_r, MOSI};
                            rx_valid_s = 1'b1;
                            if (state_r == READ_ADD) begin
                                rd_addr_done_s = 1'b1;
                            end else if (state_r == READ_DATA) begin
                                wait_act_s = 1'b1;
                                wait_cnt_s = '0;
                            end else begin
                                rd_addr_done_s = rd_addr_done_r;
                            end
                        end else begin
                            rx_valid_s = 1'b0;
                        end
                    end else begin
                        shift_s = shift_r;
                    end

                    // Read-data phase: the rx_valid cycle is skipped because the
                    // RAM only registers dout one edge after it sees the strobe.
                    if (state_r == READ_DATA) begin
                        if (wait_act_r && !rx_valid) begin
                            if (tx_valid) begin
                                tx_shift_s = tx_data;
                                tx_cnt_s   = TX_CW'(TX_W);
                                wait_act_s = 1'b0;
                            end else if (wait_cnt_r == WAIT_CW'(TX_WAIT_MAX - 1)) begin
                                wait_act_s     = 1'b0;
                                rd_addr_done_s = 1'b0;
                            end else begin
                                wait_cnt_s = wait_cnt_r + WAIT_CW'(1);
                            end
                        end else if (tx_cnt_r != '0) begin
                            miso_s     = tx_shift_r[TX_W-1];
                            tx_shift_s = {tx_shift_r[TX_W-2:0], 1'b0};
                            tx_cnt_s   = tx_cnt_r - TX_CW'(1);
                            if (tx_cnt_r == TX_CW'(1)) begin
                                rd_addr_done_s = 1'b0;
                            end else begin
                                rd_addr_done_s = rd_addr_done_r;
                            end
                        end else begin
                            miso_s = 1'b0;
                        end
                    end else begin
                        miso_s = 1'b0;
                    end
                end
            end

            default: begin
                state_s    = IDLE;
                tx_cnt_s   = '0;
                wait_act_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            bit_cnt_r      <= '0;
            shift_r        <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rd_addr_done_r <= 1'b0;
            tx_shift_r     <= '0;
            tx_cnt_r       <= '0;
            wait_act_r     <= 1'b0;
            wait_cnt_r     <= '0;
            MISO           <= 1'b0;
        end else begin
            state_r        <= state_s;
            bit_cnt_r      <= bit_cnt_s;
            shift_r        <= shift_s;
            rx_data        <= rx_data_s;
            rx_valid       <= rx_valid_s;
            rd_addr_done_r <= rd_addr_done_s;
            tx_shift_r     <= tx_shift_s;
            tx_cnt_r       <= tx_cnt_s;
            wait_act_r     <= wait_act_s;
            wait_cnt_r     <= wait_cnt_s;
            MISO           <= miso_s;
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_ctrl.sv
// Self-checking bench for spi_ram_slave_ctrl: directed scenarios followed by
// randomized frames, all checked against a frame-level reference model.
module tb_spi_ram_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: last delivered word and whether a read address is pending.
    logic [9:0] m_last;
    logic       m_addr_done;

    spi_ram_slave_ctrl #(.RX_W(10), .TX_W(8), .TX_WAIT_MAX(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net in case the run stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
    endtask

    // Outputs expected when nothing is being delivered.
    task automatic quiet(input string tag);
        chk({tag, "_rxv"},  {31'd0, rx_valid}, 32'd0);
        chk({tag, "_miso"}, {31'd0, MISO},     32'd0);
        chk({tag, "_rxd"},  {22'd0, rx_data},  {22'd0, m_last});
    endtask

    // One SS_n-low frame. nbits<10 deselects early; d = sampling edge index at
    // which the RAM answers (>=15 means too late); abort_n<8 deselects after
    // that many MISO bits.
    task automatic do_frame(input logic [9:0] word, input int nbits, input int d,
                            input int abort_n, input logic [7:0] rdata);
        int   kind;
        int   k;
        logic stop;
        logic exp_miso;
        logic keep;
        kind = (word[9] == 1'b0) ? 0 : (m_addr_done ? 2 : 1);
        MOSI = 1'($urandom_range(0, 1));
        noise();
        SS_n = 1'b0;
        tick();
        quiet("sel");
        for (int b = 0; b < nbits; b++) begin
            MOSI = word[9-b];
            noise();
            tick();
            if (b < 9) begin
                quiet("shift");
            end else begin
                chk("strobe_rxv",  {31'd0, rx_valid}, 32'd1);
                chk("strobe_rxd",  {22'd0, rx_data},  {22'd0, word});
                chk("strobe_miso", {31'd0, MISO},     32'd0);
                m_last = word;
            end
        end
        if (nbits >= 10 && kind != 2) begin
            if (kind == 1) m_addr_done = 1'b1;
            for (int e = 0; e < 3; e++) begin
                MOSI = 1'($urandom_range(0, 1));
                noise();
                tick();
                quiet("tail");
            end
        end else if (nbits >= 10) begin
            // Junk answer during the strobe cycle must be ignored.
            tx_valid = 1'b1;
            tx_data  = ~rdata;
            MOSI     = 1'($urandom_range(0, 1));
            tick();
            quiet("rxv_cycle");
            tx_valid = (d == 0);
            tx_data  = (d == 0) ? rdata : 8'($urandom);
            stop = 1'b0;
            for (int j = 0; j <= d + 9 && !stop; j++) begin
                MOSI = 1'($urandom_range(0, 1));
                tick();
                k = j - 1 - d;
                exp_miso = (d < 15 && k >= 0 && k < 8) ? rdata[7-k] : 1'b0;
                chk("miso_bit",    {31'd0, MISO},     {31'd0, exp_miso});
                chk("no_restrobe", {31'd0, rx_valid}, 32'd0);
                chk("rx_hold",     {22'd0, rx_data},  {22'd0, m_last});
                if (d < 15 && abort_n < 8 && j == d + abort_n) stop = 1'b1;
                tx_valid = (j + 1 == d);
                tx_data  = (j + 1 == d) ? rdata : 8'($urandom);
            end
            keep = (d < 15 && abort_n < 8);
            if (!keep) m_addr_done = 1'b0;
        end else begin
            kind = kind;  // incomplete frame: model unchanged
        end
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        tick();
        quiet("desel");
    endtask

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        m_last = 10'h000; m_addr_done = 1'b0;
        tick();
        tick();
        quiet("reset");
        rst = 1'b0;
        tick();

        // Write address then write data.
        do_frame(10'h02A, 10, 0, 8, 8'h00);
        do_frame(10'h1C3, 10, 0, 8, 8'h00);
        // Read address, then read data answered one edge after the strobe.
        do_frame(10'h22A, 10, 0, 8, 8'h00);
        do_frame(10'h300, 10, 0, 8, 8'hC3);
        // Read command without pending address is a read-address frame.
        do_frame(10'h3A5, 10, 0, 8, 8'h5A);
        // Abort after 4 MISO bits keeps the address; next read goes to data.
        do_frame(10'h300, 10, 1, 4, 8'h96);
        do_frame(10'h3FF, 10, 2, 8, 8'h3C);
        // Timeout, then the next read is an address again.
        do_frame(10'h211, 10, 0, 8, 8'h00);
        do_frame(10'h300, 10, 15, 8, 8'hAA);
        do_frame(10'h201, 10, 0, 8, 8'h00);
        // Answer on the last permitted sampling edge.
        do_frame(10'h300, 10, 14, 8, 8'h81);
        // Incomplete frame.
        do_frame(10'h155, 6, 0, 8, 8'h00);

        // Reset in the middle of a write frame.
        do_frame(10'h2F0, 10, 0, 8, 8'h00);
        SS_n = 1'b0;
        tick();
        for (int b = 0; b < 5; b++) begin
            MOSI = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1; SS_n = 1'b1;
        tick();
        m_last = 10'h000; m_addr_done = 1'b0;
        quiet("midrst");
        rst = 1'b0;
        for (int e = 0; e < 12; e++) begin
            MOSI = 1'($urandom_range(0, 1));
            tick();
            quiet("postrst");
        end
        do_frame(10'h3C3, 10, 0, 8, 8'h00);

        // Randomized frames.
        for (int n = 0; n < 60; n++) begin
            logic [9:0] w;
            int nb, dd, ab;
            w  = 10'($urandom_range(0, 1023));
            nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : 10;
            dd = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 14));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8;
            do_frame(w, nb, dd, ab, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
